// File: rtl/fixedpoint_divider.sv
// rtl/fixedpoint_divider.sv - iterative sign-magnitude Q7.8 fixed-point divider
//
// Result = A / B, restoring division with one quotient bit per clock behind a
// start/done handshake. Flags use the NZVC layout of the datapath ALU.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   start      operation request, sampled only while ready=1
//   A, B       dividend / divisor, sign-magnitude
//   ready      high while idle
//   busy       high while calculating or completing (= !ready)
//   done       one-cycle completion pulse; Result/NZVCFlags valid from this cycle
//   Result     quotient, sign-magnitude, held until the next completion
//   NZVCFlags  [3]N [2]Z [1]V saturated [0]C divide-by-zero, held with Result

module fixedpoint_divider #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       NZVCFlags
);

  localparam int MAG  = WIDTH - 1;
  localparam int ITER = MAG + FRAC;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ITER-1:0] dividend;
  logic [ITER-1:0] quot;
  logic [MAG-1:0]  divisor;
  logic [MAG-1:0]  rem;
  logic [CW-1:0]   cnt;
  logic            sign;

  // Operand decode for the accepting edge
  logic b_zero;
  logic in_sign;
  assign b_zero  = (B[MAG-1:0] == '0);
  assign in_sign = A[MAG] ^ B[MAG];

  // One restoring step. rem is always below divisor, so the shifted partial
  // remainder fits in MAG+1 bits and the restored remainder back in MAG bits.
  logic [MAG:0]    rem_shift;
  logic [MAG:0]    diff;
  logic            rem_ge;
  logic [MAG-1:0]  rem_next;
  logic [ITER-1:0] quot_next;

  assign rem_shift = {rem, dividend[ITER-1]};
  assign diff      = rem_shift - {1'b0, divisor};
  assign rem_ge    = (rem_shift >= {1'b0, divisor});
  assign rem_next  = rem_ge ? diff[MAG-1:0] : rem_shift[MAG-1:0];
  assign quot_next = {quot[ITER-2:0], rem_ge};

  // Final formatting of the completed quotient: saturate when any bit above
  // the magnitude field is set, and never produce a negative zero.
  logic           ovf;
  logic [MAG-1:0] q_mag;
  logic           q_zero;
  logic           q_sign;

  assign ovf    = |quot_next[ITER-1:MAG];
  assign q_mag  = ovf ? {MAG{1'b1}} : quot_next[MAG-1:0];
  assign q_zero = (q_mag == '0);
  assign q_sign = sign & ~q_zero;

  // Bits that shift out of the datapath and are intentionally dropped
  logic unused_bits;
  assign unused_bits = diff[MAG] ^ quot[ITER-1];

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = b_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt == '0) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign ready = (state == S_IDLE);
  assign busy  = ~ready;
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dividend  <= '0;
      quot      <= '0;
      divisor   <= '0;
      rem       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      Result    <= '0;
      NZVCFlags <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            dividend <= {A[MAG-1:0], {FRAC{1'b0}}};
            divisor  <= B[MAG-1:0];
            sign     <= in_sign;
            rem      <= '0;
            quot     <= '0;
            cnt      <= CW'(ITER - 1);
            if (b_zero) begin
              Result    <= {in_sign, {MAG{1'b1}}};
              NZVCFlags <= {in_sign, 1'b0, 1'b0, 1'b1};
            end
          end
        end
        S_CALC: begin
          dividend <= {dividend[ITER-2:0], 1'b0};
          rem      <= rem_next;
          quot     <= quot_next;
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            Result    <= {q_sign, q_mag};
            NZVCFlags <= {q_sign, q_zero, ovf, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixedpoint_divider.sv
// tb/tb_fixedpoint_divider.sv - directed vector and scoreboard bench for fixedpoint_divider

module tb_fixedpoint_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] Result;
  logic [3:0]  NZVCFlags;

  int nvec  = 0;
  int nfail = 0;

  fixedpoint_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .Result    (Result),
    .NZVCFlags (NZVCFlags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one operation from IDLE; operands are scrambled right after the
  // sampling edge. lat counts clock edges after the sampling edge until done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic [3:0] flg,
                        output int lat, output bit got);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = done;
    res = Result;
    flg = NZVCFlags;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain integer division with saturation and sign rules
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [3:0] flg, output int lat);
    int unsigned ma, mb, q;
    logic s;
    ma = a[14:0];
    mb = b[14:0];
    s = a[15] ^ b[15];
    if (mb == 0) begin
      res = {s, 15'h7FFF};
      flg = {s, 1'b0, 1'b0, 1'b1};
      lat = 0;
    end else begin
      q = (ma * 256) / mb;
      lat = 23;
      if (q > 32767) begin
        res = {s, 15'h7FFF};
        flg = {s, 1'b0, 1'b1, 1'b0};
      end else if (q == 0) begin
        res = 16'h0000;
        flg = 4'b0100;
      end else begin
        res = {s, q[14:0]};
        flg = {s, 1'b0, 1'b0, 1'b0};
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] r, er;
    logic [3:0]  f, ef;
    int          lat, elat, ndone;
    bit          got;

    vecs.push_back('{16'h0300, 16'h0200, 16'h0180, 4'b0000, 23});
    vecs.push_back('{16'h8180, 16'h0080, 16'h8300, 4'b1000, 23});
    vecs.push_back('{16'h0100, 16'h8000, 16'hFFFF, 4'b1001, 0});
    vecs.push_back('{16'h0100, 16'h0000, 16'h7FFF, 4'b0001, 0});
    vecs.push_back('{16'h6400, 16'h0040, 16'h7FFF, 4'b0010, 23});
    vecs.push_back('{16'h8000, 16'h0100, 16'h0000, 4'b0100, 23});
    vecs.push_back('{16'h0001, 16'h7FFF, 16'h0000, 4'b0100, 23});
    vecs.push_back('{16'h8100, 16'h8100, 16'h0100, 4'b0000, 23});
    vecs.push_back('{16'h0001, 16'h0100, 16'h0001, 4'b0000, 23});
    vecs.push_back('{16'h7FFF, 16'h0100, 16'h7FFF, 4'b0000, 23});
    vecs.push_back('{16'h7FFF, 16'h00FF, 16'h7FFF, 4'b0010, 23});
    vecs.push_back('{16'h8001, 16'h0003, 16'h8055, 4'b1000, 23});
    vecs.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 4'b1010, 23});
    vecs.push_back('{16'h8000, 16'h8000, 16'h7FFF, 4'b0001, 0});

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", 32'(ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'(Result), 0);
    check("reset_flags", 32'(NZVCFlags), 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, r, f, lat, got);
      check($sformatf("vec%0d_done", i), 32'(got), 1);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flg));
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
      check($sformatf("vec%0d_ready_after", i), 32'(ready), 1);
    end

    // start held high through most of CALC: exactly one completion
    @(negedge clk);
    A = 16'h0300;
    B = 16'h0200;
    start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 20) start = 1'b0;
      if (c == 2) check("held_start_busy", 32'(busy), 1);
      if (done) begin
        ndone++;
        check("held_start_result", 32'(Result), 32'h0180);
        check("held_start_flags", 32'(NZVCFlags), 0);
      end
    end
    check("held_start_done_count", 32'(ndone), 1);

    // reset 10 clocks into CALC
    @(negedge clk);
    A = 16'h8180;
    B = 16'h0080;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready", 32'(ready), 1);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", 32'(Result), 0);
    check("midrst_flags", 32'(NZVCFlags), 0);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 0);
    run_op(16'h8180, 16'h0080, r, f, lat, got);
    check("post_rst_result", 32'(r), 32'h8300);
    check("post_rst_flags", 32'(f), 32'b1000);

    // random scoreboard
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 3 == 0) b = {b[15], 7'd0, b[7:0]};
      if (i % 7 == 0) b = {b[15], 15'd0};
      model(a, b, er, ef, elat);
      run_op(a, b, r, f, lat, got);
      check($sformatf("rnd%0d_done a=%h b=%h", i, a, b), 32'(got), 1);
      check($sformatf("rnd%0d_latency a=%h b=%h", i, a, b), 32'(lat), 32'(elat));
      check($sformatf("rnd%0d_result a=%h b=%h", i, a, b), 32'(r), 32'(er));
      check($sformatf("rnd%0d_flags a=%h b=%h", i, a, b), 32'(f), 32'(ef));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
